grf_wb_queue: RTL and testbench



---
 rtl/grf_pkg.sv | 18 +
 rtl/wbq_lookup.sv | 47 ++++
 rtl/grf_wb_queue.sv | 148 ++++++++++++++
 tb/tb_grf_wb_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared GRF types and constants for the write-back queue.
// Provides default register address/data widths, the hard-wired zero register
// index, and the queue entry payload type.
package grf_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // Writes to this register are architecturally discarded.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match priority search over the write-back queue entries.
// Scans from the entry just below tail back towards head, so the first valid
// address match found is the most recently accepted one.
// Ports:
//   valid_i, addr_i  per-entry valid bit and destination register
//   tail_i           queue tail pointer (next free slot)
//   key_i            address to search for; zero never matches
//   skip_en_i/idx_i  optionally exclude one slot from the search
//   hit_c, idx_c     match flag and index of the youngest match
module wbq_lookup #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [$clog2(DEPTH)-1:0]     tail_i,
  input  logic [ADDR_W-1:0]            key_i,
  input  logic                         skip_en_i,
  input  logic [$clog2(DEPTH)-1:0]     skip_idx_i,
  output logic                         hit_c,
  output logic [$clog2(DEPTH)-1:0]     idx_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] scan_idx;
  logic             found;
  logic [PTR_W-1:0] found_idx;

  // Walk age order youngest-first; the first hit locks the result.
  always_comb begin
    scan_idx  = '0;
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      scan_idx = tail_i - PTR_W'(k);
      if (!found && valid_i[scan_idx] && (addr_i[scan_idx] == key_i) &&
          (key_i != '0) && !(skip_en_i && (scan_idx == skip_idx_i))) begin
        found     = 1'b1;
        found_idx = scan_idx;
      end
    end
    hit_c = found;
    idx_c = found_idx;
  end

endmodule

// File: rtl/grf_wb_queue.sv
// In-order write buffer in front of the GRF write port.
// Accepts register writes from producers, drains one per cycle to the GRF
// (stalled by wb_hold) and exposes two bypass lookup ports for pending values.
// Optional build macro: GRF_WBQ_COALESCE_EN merges a request into the youngest
// matching non-head entry instead of allocating a new slot.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   enq_valid/ready/addr/data   producer write request handshake
//   wb_hold                     stall draining this cycle
//   grf_we/waddr/wdata          GRF write port (driven from head)
//   lk_addr*/lk_hit*/lk_data*   combinational bypass lookups
//   count, empty, full          occupancy status
module grf_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = grf_pkg::ADDR_W,
  parameter int unsigned DATA_W = grf_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [ADDR_W-1:0]          enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       wb_hold,
  output logic                       grf_we,
  output logic [ADDR_W-1:0]          grf_waddr,
  output logic [DATA_W-1:0]          grf_wdata,
  input  logic [ADDR_W-1:0]          lk_addr1,
  input  logic [ADDR_W-1:0]          lk_addr2,
  output logic                       lk_hit1,
  output logic                       lk_hit2,
  output logic [DATA_W-1:0]          lk_data1,
  output logic [DATA_W-1:0]          lk_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

  logic             accept;
  logic             push;
  logic [PTR_W-1:0] lk1_idx, lk2_idx;

  // Status and drain are pure functions of the registered queue state.
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign enq_ready = !full;
  assign grf_we    = !empty && !wb_hold;
  assign grf_waddr = empty ? '0 : addr_q[head_q];
  assign grf_wdata = empty ? '0 : data_q[head_q];

  // Requests to the zero register are accepted but never stored.
  assign accept = enq_valid && enq_ready && (enq_addr != ADDR_W'(grf_pkg::REG_ZERO));

  wbq_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lk1 (
    .valid_i(valid_q), .addr_i(addr_q), .tail_i(tail_q), .key_i(lk_addr1),
    .skip_en_i(1'b0), .skip_idx_i(head_q), .hit_c(lk_hit1), .idx_c(lk1_idx)
  );

  wbq_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lk2 (
    .valid_i(valid_q), .addr_i(addr_q), .tail_i(tail_q), .key_i(lk_addr2),
    .skip_en_i(1'b0), .skip_idx_i(head_q), .hit_c(lk_hit2), .idx_c(lk2_idx)
  );

  assign lk_data1 = lk_hit1 ? data_q[lk1_idx] : '0;
  assign lk_data2 = lk_hit2 ? data_q[lk2_idx] : '0;

`ifdef GRF_WBQ_COALESCE_EN
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;

  // Head is excluded: it may be on the GRF port right now, so merging into it
  // could lose the new value.
  wbq_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_coal (
    .valid_i(valid_q), .addr_i(addr_q), .tail_i(tail_q), .key_i(enq_addr),
    .skip_en_i(1'b1), .skip_idx_i(head_q), .hit_c(coal_hit), .idx_c(coal_idx)
  );

  assign push = accept && !coal_hit;
`else
  assign push = accept;
`endif

  // Next-state for pointers, occupancy and entry storage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (grf_we) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = enq_addr;
      data_d[tail_q]  = enq_data;
      tail_d          = tail_q + PTR_W'(1);
    end

`ifdef GRF_WBQ_COALESCE_EN
    if (accept && coal_hit) begin
      data_d[coal_idx] = enq_data;
    end
`endif

    case ({push, grf_we})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed self-checking bench for grf_wb_queue (DEPTH=4, ADDR_W=5, DATA_W=32).
module tb_grf_wb_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [4:0]  enq_addr = '0;
  logic [31:0] enq_data = '0;
  logic        wb_hold = 1'b0;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic [4:0]  lk_addr1 = '0;
  logic [4:0]  lk_addr2 = '0;
  logic        lk_hit1, lk_hit2;
  logic [31:0] lk_data1, lk_data2;
  logic [2:0]  count;
  logic        empty, full;

  int tests = 0;
  int failed = 0;

  grf_wb_queue dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_data(enq_data),
    .wb_hold(wb_hold),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [4:0] a, input logic [31:0] d);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{5'd3, 5'd4, 5'd3, 5'd7};
    exp_d = '{32'hA, 32'hB, 32'hC, 32'hD};

    // Reset state
    step();
    step();
    reset = 1'b0;
    lk_addr1 = 5'd5;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_we", grf_we, 0);
    check("rst_count", count, 0);
    check("rst_hit", lk_hit1, 0);

    // Single enqueue; lookup must not see the same-cycle request
    enq_valid = 1'b1; enq_addr = 5'd5; enq_data = 32'h1234;
    #1;
    check("same_cyc_hit", lk_hit1, 0);
    step();
    enq_valid = 1'b0;
    #1;
    check("one_we", grf_we, 1);
    check("one_waddr", grf_waddr, 5);
    check("one_wdata", grf_wdata, 32'h1234);
    check("one_count", count, 1);
    check("one_hit", lk_hit1, 1);
    check("one_lkdata", lk_data1, 32'h1234);
    step();
    check("one_empty", empty, 1);
    check("one_we_after", grf_we, 0);
    check("one_waddr_idle", grf_waddr, 0);
    check("one_hit_after", lk_hit1, 0);

    // Fill under hold, lookup youngest match, then drain in order
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) enq(exp_a[i], exp_d[i]);
    lk_addr1 = 5'd3;
    lk_addr2 = 5'd9;
    #1;
    check("fill_full", full, 1);
    check("fill_ready", enq_ready, 0);
    check("fill_count", count, 4);
    check("fill_we", grf_we, 0);
    check("lk1_hit", lk_hit1, 1);
    check("lk1_data", lk_data1, 32'hC);
    check("lk2_hit", lk_hit2, 0);
    check("lk2_data", lk_data2, 0);
    enq(5'd10, 32'hEE);
    check("full_no_accept", count, 4);
    wb_hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_we", i), grf_we, 1);
      check($sformatf("drain%0d_addr", i), grf_waddr, exp_a[i]);
      check($sformatf("drain%0d_data", i), grf_wdata, exp_d[i]);
      if (i == 1) check("lk_after_pop", lk_data1, 32'hC);
      step();
    end
    check("drain_empty", empty, 1);
    check("drain_we_off", grf_we, 0);

    // Zero-register request is swallowed
    lk_addr1 = 5'd0;
    lk_addr2 = 5'd0;
    enq(5'd0, 32'hFFFF);
    check("zero_count", count, 0);
    check("zero_we", grf_we, 0);
    check("zero_empty", empty, 1);
    check("zero_hit1", lk_hit1, 0);
    check("zero_hit2", lk_hit2, 0);

    // Continuous stream wraps the pointers several times
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1'b1;
      enq_addr  = 5'(i + 1);
      enq_data  = 32'h100 + 32'(i);
      step();
      check($sformatf("strm%0d_count", i), count, 1);
      check($sformatf("strm%0d_we", i), grf_we, 1);
      check($sformatf("strm%0d_addr", i), grf_waddr, 5'(i + 1));
      check($sformatf("strm%0d_data", i), grf_wdata, 32'h100 + 32'(i));
    end
    enq_valid = 1'b0;
    step();
    check("strm_empty", empty, 1);

    // Reset with pending entries and a concurrent request
    wb_hold = 1'b1;
    enq(5'd11, 32'h11);
    enq(5'd12, 32'h12);
    enq(5'd13, 32'h13);
    check("pre_rst_count", count, 3);
    lk_addr1 = 5'd12;
    reset = 1'b1;
    enq_valid = 1'b1; enq_addr = 5'd14; enq_data = 32'h14;
    step();
    reset = 1'b0;
    enq_valid = 1'b0;
    wb_hold = 1'b0;
    #1;
    check("rst2_empty", empty, 1);
    check("rst2_count", count, 0);
    check("rst2_we", grf_we, 0);
    check("rst2_hit", lk_hit1, 0);
    step();
    check("rst2_we_later", grf_we, 0);
    check("rst2_count_later", count, 0);

`ifdef GRF_WBQ_COALESCE_EN
    // Coalesce into a non-head entry
    wb_hold = 1'b1;
    enq(5'd6, 32'd1);
    enq(5'd8, 32'd2);
    enq(5'd8, 32'd3);
    lk_addr1 = 5'd8;
    #1;
    check("coal_count", count, 2);
    check("coal_lk", lk_data1, 32'd3);
    wb_hold = 1'b0;
    #1;
    check("coal_w0_addr", grf_waddr, 6);
    check("coal_w0_data", grf_wdata, 1);
    step();
    check("coal_w1_we", grf_we, 1);
    check("coal_w1_addr", grf_waddr, 8);
    check("coal_w1_data", grf_wdata, 3);
    step();
    check("coal_done", empty, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
